// File: rtl/axis_fft_framer_if.sv
// AXI-Stream sample channel shared by the framer's upstream and downstream
// ports. The slave side carries no tlast: frame boundaries are generated
// by the framer itself.
interface axis_fft_framer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_fft_framer.sv
// Cuts a free-running complex sample stream into FFT_LEN-sample AXI-Stream
// frames. Framing starts and stops only on frame boundaries under en, and a
// two-entry skid buffer keeps full throughput with registered outputs.
module axis_fft_framer #(
  parameter int WIDTH   = 32,
  parameter int FFT_LEN = 32,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       en,
  axis_fft_framer_if.slave           s_axis,
  axis_fft_framer_if.master          m_axis,
  output logic [$clog2(FFT_LEN)-1:0] sample_idx,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic                       busy
);

  localparam int IDX_W = $clog2(FFT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              out_vld_q, out_vld_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic              skid_last_q, skid_last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;

  logic accept, xfer, last_in;

  assign accept  = s_axis.tvalid & rdy_q;
  assign xfer    = out_vld_q & m_axis.tready;
  assign last_in = (idx_q == IDX_LAST);

  // Frame-level FSM: leave RUN only after the last sample of a frame is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (accept && last_in && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer, sample index, frame counter and registered input ready.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (!out_vld_q || xfer) begin
      // Output slot frees up this cycle. A full skid implies ready was low,
      // so a skid refill and a fresh accept never compete for the slot.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d  = 1'b1;
        out_data_d = s_axis.tdata;
        out_last_d = last_in;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_data_d = s_axis.tdata;
      skid_last_d = last_in;
    end
    // FFT_LEN is a power of two, so the natural overflow wraps the index.
    idx_d  = accept ? idx_q + IDX_W'(1) : idx_q;
    fcnt_d = (xfer && out_last_q) ? fcnt_q + CNT_W'(1) : fcnt_q;
    rdy_d  = (state_d == RUN) && !skid_vld_d;
  end

  // Control state and the output register; reset discards any buffered beat.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      skid_vld_q <= 1'b0;
      idx_q      <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      skid_vld_q <= skid_vld_d;
      idx_q      <= idx_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Skid payload is only meaningful while skid_vld_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_last_q <= skid_last_d;
  end

  assign s_axis.tready = rdy_q;
  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tlast  = out_last_q;
  assign sample_idx    = idx_q;
  assign frame_cnt     = fcnt_q;
  assign busy          = (state_q == RUN) | out_vld_q | skid_vld_q;

endmodule

// File: tb/tb_axis_fft_framer.sv
// Scoreboard bench for axis_fft_framer: an input monitor queues every accepted
// sample with its expected tlast, an output monitor pops and compares each
// transferred beat, tracks the expected frame count and checks stall stability.
module tb_axis_fft_framer;
  localparam int WIDTH   = 32;
  localparam int FFT_LEN = 32;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 5;

  logic             clk = 1'b0;
  logic             aresetn = 1'b0;
  logic             en = 1'b0;
  logic [IDX_W-1:0] sample_idx;
  logic [CNT_W-1:0] frame_cnt;
  logic             busy;

  axis_fft_framer_if #(.WIDTH(WIDTH)) s_if ();
  axis_fft_framer_if #(.WIDTH(WIDTH)) m_if ();

  axis_fft_framer #(.WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .en         (en),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .sample_idx (sample_idx),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int               total = 0;
  int               bad = 0;
  logic [WIDTH:0]   exp_q[$];
  int               tb_idx = 0;
  logic [CNT_W-1:0] exp_fc = '0;
  int               n_acc = 0;
  int               n_xfer = 0;
  logic [WIDTH-1:0] next_val = '0;
  bit               acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Queue each sample the DUT is about to accept, tagging the frame's last one.
  task automatic in_mon();
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        exp_q.delete();
        tb_idx = 0;
        n_acc  = 0;
      end else if (s_if.tvalid && s_if.tready) begin
        exp_q.push_back({(tb_idx == FFT_LEN - 1), s_if.tdata});
        tb_idx = (tb_idx + 1) % FFT_LEN;
        n_acc++;
      end
    end
  endtask

  task automatic out_mon();
    bit             pst = 1'b0;
    logic [WIDTH:0] pv = '0;
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        exp_fc = '0;
        pst    = 1'b0;
        n_xfer = 0;
      end else begin
        chk("frame_cnt_track", frame_cnt, exp_fc);
        if (pst) chk("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, pv});
        if (m_if.tvalid && m_if.tready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat: got unexpected %0h expected no beat", m_if.tdata);
          end else begin
            e = exp_q.pop_front();
            if ({m_if.tlast, m_if.tdata} !== e) begin
              bad++;
              $display("FAIL beat: got last=%0b data=%0h expected last=%0b data=%0h",
                       m_if.tlast, m_if.tdata, e[WIDTH], e[WIDTH-1:0]);
            end
            if (e[WIDTH]) exp_fc = exp_fc + 1'b1;
          end
          n_xfer++;
        end
        pst = m_if.tvalid && !m_if.tready;
        pv  = {m_if.tlast, m_if.tdata};
      end
    end
  endtask

  // One clock: drive just after the rising edge, settle past the falling edge.
  task automatic cyc(input bit e, input bit v, input bit r);
    @(posedge clk);
    #1;
    en          = e;
    s_if.tvalid = v;
    s_if.tdata  = next_val;
    m_if.tready = r;
    @(negedge clk);
    acc = s_if.tvalid && s_if.tready;
    if (acc) next_val++;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cyc(en, 1'b0, 1'b1);
  endtask

  initial begin
    int g;
    int cnt;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    fork
      in_mon();
      out_mon();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_sample_idx", sample_idx, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    aresetn = 1'b1;

    // Continuous ramp: 96 samples, one output beat per cycle after latency
    for (int c = 0; c < 100; c++) begin
      cyc(1'b1, n_acc < 96, 1'b1);
      chk($sformatf("ramp_tvalid_c%0d", c), m_if.tvalid, (c >= 2 && c <= 97));
    end
    chk("ramp_frame_cnt", frame_cnt, 3);
    chk("ramp_sample_idx", sample_idx, 0);

    // Downstream stall for 8 cycles mid-frame
    repeat (5) cyc(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk($sformatf("stall_s_tready_%0d", k), s_if.tready, (k == 0));
    end
    chk("stall_buffered", n_acc - n_xfer, 2);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 1'b1);
      chk($sformatf("release_tvalid_%0d", k), m_if.tvalid, 1);
    end
    g = 0;
    while ((n_acc % FFT_LEN) != 0 && g < 100) begin
      cyc(1'b1, 1'b1, 1'b1);
      g++;
    end
    chk("stall_finish_timeout", g < 100, 1);
    drain();
    chk("stall_frame_cnt", frame_cnt, 4);

    // en dropped at sample_idx 10: the frame still completes
    g = 0;
    while (sample_idx != 10 && g < 100) begin
      cyc(1'b1, 1'b1, 1'b1);
      g++;
    end
    chk("endrop_reach_timeout", g < 100, 1);
    cnt = acc;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 1'b1, 1'b1);
      cnt += acc;
    end
    chk("endrop_accepts", cnt, 22);
    chk("endrop_s_tready", s_if.tready, 0);
    chk("endrop_busy", busy, 0);
    chk("endrop_m_tvalid", m_if.tvalid, 0);
    chk("endrop_sample_idx", sample_idx, 0);
    chk("endrop_frame_cnt", frame_cnt, 5);
    cyc(1'b1, 1'b0, 1'b1);
    chk("reen_ready_before", s_if.tready, 0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("reen_ready_after", s_if.tready, 1);
    chk("reen_sample_idx", sample_idx, 0);

    // Reset mid-frame with two beats buffered
    g = 0;
    while (sample_idx != 15 && g < 100) begin
      cyc(1'b1, 1'b1, 1'b1);
      g++;
    end
    chk("rstmid_reach_timeout", g < 100, 1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    chk("rstmid_buffered", n_acc - n_xfer, 2);
    chk("rstmid_sample_idx", sample_idx, 17);
    @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rstmid_m_tvalid", m_if.tvalid, 0);
    chk("rstmid_m_tdata", m_if.tdata, 0);
    chk("rstmid_m_tlast", m_if.tlast, 0);
    chk("rstmid_s_tready", s_if.tready, 0);
    chk("rstmid_idx", sample_idx, 0);
    chk("rstmid_frame_cnt", frame_cnt, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    aresetn = 1'b1;
    g = 0;
    while (n_acc < 32 && g < 200) begin
      cyc(1'b1, 1'b1, 1'b1);
      g++;
    end
    chk("rstmid_frame_timeout", g < 200, 1);
    drain();
    chk("rstmid_post_frame_cnt", frame_cnt, 1);

    // Random valid/ready over 10 frames
    g = 0;
    while (n_acc < 352 && g < 5000) begin
      cyc(1'b1, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      g++;
    end
    chk("random_timeout", g < 5000, 1);
    drain();
    chk("random_frame_cnt", frame_cnt, 11);
    chk("random_sample_idx", sample_idx, 0);

    // Six more frames: 17 since reset, so the 4-bit counter wraps to 1
    g = 0;
    while (n_acc < 544 && g < 1000) begin
      cyc(1'b1, 1'b1, 1'b1);
      g++;
    end
    chk("wrap_timeout", g < 1000, 1);
    drain();
    chk("wrap_frame_cnt", frame_cnt, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_fft_framer.md
# axis_fft_framer

Frames the free-running complex sample stream from `adc_model` into FFT-length AXI-Stream frames ahead of `xfft_0`. It counts accepted samples and asserts `m_axis_tlast` on the last sample of every `FFT_LEN`-sample frame. It starts and stops only on frame boundaries under `en`. A two-entry skid buffer gives full throughput with registered outputs, so `event_tlast_unexpected`/`event_tlast_missing` from the FFT stay quiet.

## Interface
- `WIDTH`, 32, complex sample width in bits, packed as `{im, re}`.
- `FFT_LEN`, 32, samples per frame; power of two, ≥ 2.
- `CNT_W`, 32, width of `frame_cnt`.

- `clk` in 1: single clock for all logic.
- `aresetn` in 1: asynchronous, active-low reset.
- `en` in 1: arm framing; sampled only at frame boundaries.
- `s_axis_tdata` in `WIDTH`: upstream sample.
- `s_axis_tvalid` in 1: upstream valid.
- `s_axis_tready` out 1: framer ready; registered.
- `m_axis_tdata` out `WIDTH`: sample toward the FFT.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: FFT `s_axis_data_tready`.
- `m_axis_tlast` out 1: high on sample `FFT_LEN-1` of each frame.
- `sample_idx` out `$clog2(FFT_LEN)`: index of the next sample to be accepted.
- `frame_cnt` out `CNT_W`: count of frames fully delivered downstream.
- `busy` out 1: high while in RUN or while the buffer holds data.

## Operation
- An input beat is accepted when `s_axis_tvalid & s_axis_tready`.
- An output beat is transferred when `m_axis_tvalid & m_axis_tready`.
- FSM states:
  - IDLE: `s_axis_tready`=0. Moves to RUN on the cycle after `en`=1 is sampled.
  - RUN: accepts input. On accepting the sample with `sample_idx`==`FFT_LEN-1`: returns to IDLE if `en`=0 in that cycle, otherwise stays in RUN.
- Deasserting `en` mid-frame never truncates a frame. The current frame always completes.
- `sample_idx` increments on each accept and wraps from `FFT_LEN-1` to 0. It holds in IDLE.
- The tlast bit is computed at accept time (`sample_idx`==`FFT_LEN-1`) and travels with its data through the buffer.
- Skid buffer: one output register plus one skid register.
  - Accept with the output register empty or draining writes the output register.
  - Accept while the output register is stalled writes the skid register.
  - A transfer while the skid register is full moves skid → output in the same cycle.
- `s_axis_tready` (registered) = RUN & skid empty, evaluated for the next cycle.
- Output data and tlast are held stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.
- `frame_cnt` increments on each transferred beat with `m_axis_tlast`=1 and wraps modulo 2^`CNT_W`.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - both buffer entries invalid, with buffered beats discarded;
  - `sample_idx` and `frame_cnt` to 0.
- Reset mid-frame abandons that frame. The next frame restarts at index 0.
- Latency: a beat accepted in cycle N is presented in cycle N+1 if the output register is empty or transferring in N.
- Throughput: one beat per cycle sustained while `m_axis_tready`=1.
- Stall: with `m_axis_tready`=0, at most 2 beats are accepted before `s_axis_tready` falls (1 cycle after the skid fills). No beat is lost or duplicated.
- `en` rising in IDLE: `s_axis_tready` rises 1 cycle later.
- Last accept with `en`=0: `s_axis_tready` is 0 in the next cycle. `busy` falls once the buffer drains.
- Simultaneous accept and transfer with the skid full cannot occur, because ready is low then.
- Simultaneous skid→output move and a new accept is legal only when the skid was empty at the start of the cycle.

## Test plan
- Continuous ramp 0,1,2… with `en`=1 and `m_axis_tready`=1, `FFT_LEN`=32 → `m_axis_tlast` on values 31, 63, 95. One beat per cycle after 1-cycle latency. `frame_cnt`=3 after value 95 transfers.
- Random `m_axis_tready` (50%) and random `s_axis_tvalid` over 10 frames → output sequence identical to input. tlast on every 32nd beat. Data stable during stalls. `frame_cnt`=10.
- `m_axis_tready`=0 held for 8 cycles during streaming → exactly 2 beats buffered, `s_axis_tready`=0 thereafter. On release, both beats drain in order with no gap.
- `en` dropped at `sample_idx`=10 → samples 10–31 still accepted, tlast on 31, then `s_axis_tready`=0 and `busy`=0 after drain. Re-raising `en` restarts at `sample_idx`=0.
- `aresetn` pulsed at `sample_idx`=17 with 2 beats buffered → all outputs 0 immediately, buffered beats never appear. After release and `en`=1, the first frame's tlast lands on the 32nd new sample.
- `CNT_W`=4, 17 frames → `frame_cnt` wraps 15→0 and reads 1 at the end.
